// File: rtl/cmp_seq_ctl.sv
// Multi-nibble magnitude compare sequenced through one shared external 4-bit signed comparator.
// Walks MS nibble to LS nibble, one per clock, and stops on the first unequal nibble.
module cmp_seq_ctl #(
  parameter int unsigned NIBBLES = 4,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic                 sysclk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic [3:0]           cmp_a,
  output logic [3:0]           cmp_b,
  input  logic                 cmp_aeb,
  input  logic                 cmp_agb,
  input  logic                 cmp_alb,
  output logic                 busy,
  output logic                 done,
  output logic                 aeb,
  output logic                 agb,
  output logic                 alb
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NIBBLES - 1);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e                 r_state;
  logic [IdxW-1:0]        r_idx;
  logic [4*NIBBLES-1:0]   r_a;
  logic [4*NIBBLES-1:0]   r_b;
  logic                   r_done;
  logic                   r_aeb;
  logic                   r_agb;
  logic                   r_alb;

  logic [3:0]             w_nib_a;
  logic [3:0]             w_nib_b;
  logic                   w_flip;
  logic                   w_eq;

  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  // Flipping bit 3 on both sides turns the comparator's signed compare into an unsigned one;
  // only the sign-carrying top nibble of a signed operand is compared raw.
  assign w_flip = !(SIGNED && (r_idx == TopIdx));

  assign cmp_a = (r_state == StRun) ? (w_nib_a ^ {w_flip, 3'b000}) : 4'h0;
  assign cmp_b = (r_state == StRun) ? (w_nib_b ^ {w_flip, 3'b000}) : 4'h0;

  // A non-one-hot result from the comparator never counts as equal.
  assign w_eq = cmp_aeb && !cmp_agb && !cmp_alb;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_aeb   <= 1'b0;
      r_agb   <= 1'b0;
      r_alb   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_idx   <= TopIdx;
            r_aeb   <= 1'b0;
            r_agb   <= 1'b0;
            r_alb   <= 1'b0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            r_state <= StIdle;
          end else if (!w_eq) begin
            r_agb   <= cmp_agb;
            r_alb   <= cmp_alb;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else if (r_idx == '0) begin
            r_aeb   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_idx <= r_idx - IdxW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy = (r_state == StRun);
  assign done = r_done;
  assign aeb  = r_aeb;
  assign agb  = r_agb;
  assign alb  = r_alb;

endmodule

// File: tb/tb_cmp_seq_ctl.sv
// Bench for cmp_seq_ctl: three instances (4 nibbles signed, 4 nibbles unsigned, 1 nibble signed)
// against a whole-operand reference model, plus directed literal checks.
module tb_cmp_seq_ctl;

  logic        sysclk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        inj = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  logic [3:0]  ca [3];
  logic [3:0]  cb [3];
  logic [2:0]  xeb, xgb, xlb;
  logic [2:0]  busy, done, aeb, agb, alb;

  int n_chk = 0;
  int n_fail = 0;
  int edges = 0;
  int t_acc = 0;
  int lat;

  int nn [3] = '{4, 4, 1};
  bit ss [3] = '{1'b1, 1'b0, 1'b1};

  always #5 sysclk = ~sysclk;

  cmp_seq_ctl #(.NIBBLES(4), .SIGNED(1'b1)) u_s4 (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .cmp_a(ca[0]), .cmp_b(cb[0]),
    .cmp_aeb(xeb[0]), .cmp_agb(xgb[0]), .cmp_alb(xlb[0]),
    .busy(busy[0]), .done(done[0]), .aeb(aeb[0]), .agb(agb[0]), .alb(alb[0])
  );

  cmp_seq_ctl #(.NIBBLES(4), .SIGNED(1'b0)) u_u4 (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .cmp_a(ca[1]), .cmp_b(cb[1]),
    .cmp_aeb(xeb[1]), .cmp_agb(xgb[1]), .cmp_alb(xlb[1]),
    .busy(busy[1]), .done(done[1]), .aeb(aeb[1]), .agb(agb[1]), .alb(alb[1])
  );

  cmp_seq_ctl #(.NIBBLES(1), .SIGNED(1'b1)) u_s1 (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .op_a(op_a[3:0]), .op_b(op_b[3:0]), .cmp_a(ca[2]), .cmp_b(cb[2]),
    .cmp_aeb(xeb[2]), .cmp_agb(xgb[2]), .cmp_alb(xlb[2]),
    .busy(busy[2]), .done(done[2]), .aeb(aeb[2]), .agb(agb[2]), .alb(alb[2])
  );

  // External CMP4: signed 4-bit compare; inj forces an illegal all-ones result.
  always_comb begin
    xeb = '0;
    xgb = '0;
    xlb = '0;
    for (int i = 0; i < 3; i++) begin
      if (inj) begin
        xeb[i] = 1'b1;
        xgb[i] = 1'b1;
        xlb[i] = 1'b1;
      end else begin
        xeb[i] = (ca[i] == cb[i]);
        xgb[i] = ($signed(ca[i]) > $signed(cb[i]));
        xlb[i] = ($signed(ca[i]) < $signed(cb[i]));
      end
    end
  end

  function automatic logic [31:0] mask_op(logic [15:0] v, int n);
    logic [31:0] m;
    m = (32'd1 << (4 * n)) - 32'd1;
    return {16'h0, v} & m;
  endfunction

  // Number of nibbles examined before the answer is known.
  function automatic int dec_count(logic [31:0] a, logic [31:0] b, int n);
    for (int k = 0; k < n; k++) begin
      if (a[4*(n-1-k) +: 4] != b[4*(n-1-k) +: 4]) return k + 1;
    end
    return n;
  endfunction

  function automatic logic [2:0] expect_res(logic [31:0] a, logic [31:0] b, int n, bit s);
    longint va, vb;
    int w;
    w  = 4 * n;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (64'sd1 <<< w);
    if (s && b[w-1]) vb = vb - (64'sd1 <<< w);
    return {va == vb, va > vb, va < vb};
  endfunction

  function automatic logic [3:0] exp_nib(logic [31:0] v, int n, bit s, int k);
    logic [3:0] x;
    int idx;
    idx = n - 1 - k;
    x = v[4*idx +: 4];
    if (!(s && idx == n - 1)) x[3] = ~x[3];
    return x;
  endfunction

  bit          m_busy [3];
  bit          m_done [3];
  int          m_k    [3];
  int          m_dec  [3];
  logic [31:0] m_a    [3];
  logic [31:0] m_b    [3];
  logic [2:0]  m_res  [3];
  logic [2:0]  m_fin  [3];

  always @(posedge sysclk) edges <= edges + 1;

  always @(posedge sysclk or negedge sys_rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!sys_rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_k[i]    <= 0;
        m_dec[i]  <= 0;
        m_a[i]    <= '0;
        m_b[i]    <= '0;
        m_res[i]  <= '0;
        m_fin[i]  <= '0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (abort) begin
            m_busy[i] <= 1'b0;
          end else if (m_k[i] + 1 == m_dec[i]) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_res[i]  <= m_fin[i];
          end else begin
            m_k[i] <= m_k[i] + 1;
          end
        end else if (start) begin
          m_a[i]    <= mask_op(op_a, nn[i]);
          m_b[i]    <= mask_op(op_b, nn[i]);
          m_res[i]  <= '0;
          m_k[i]    <= 0;
          m_busy[i] <= 1'b1;
          m_dec[i]  <= inj ? 1 : dec_count(mask_op(op_a, nn[i]), mask_op(op_b, nn[i]), nn[i]);
          m_fin[i]  <= inj ? 3'b011 :
                       expect_res(mask_op(op_a, nn[i]), mask_op(op_b, nn[i]), nn[i], ss[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sysclk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
      chk($sformatf("res%0d", i), 32'({aeb[i], agb[i], alb[i]}), 32'(m_res[i]));
      chk($sformatf("cmp_a%0d", i), 32'(ca[i]),
          m_busy[i] ? 32'(exp_nib(m_a[i], nn[i], ss[i], m_k[i])) : 32'h0);
      chk($sformatf("cmp_b%0d", i), 32'(cb[i]),
          m_busy[i] ? 32'(exp_nib(m_b[i], nn[i], ss[i], m_k[i])) : 32'h0);
    end
  end

  // Called just after an edge; the next edge accepts.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge sysclk);
    #2;
    t_acc = edges;
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge sysclk);
      #1;
      if (done[0]) begin
        l = edges - t_acc;
        return;
      end
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out%0d", tag, i),
          32'({busy[i], done[i], aeb[i], agb[i], alb[i], ca[i], cb[i]}), 32'h0);
    end
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge sysclk);
    #2 sys_rst_n = 1'b1;

    // Equal operands: full walk.
    do_start(16'h1234, 16'h1234);
    wait_done(lat);
    chk("eq_lat", 32'(lat), 32'd4);
    chk("eq_res", 32'({aeb[0], agb[0], alb[0]}), 32'b100);

    // MS nibble decides; signedness flips the answer.
    do_start(16'h8000, 16'h0001);
    wait_done(lat);
    chk("msb_lat", 32'(lat), 32'd1);
    chk("msb_res_s", 32'({aeb[0], agb[0], alb[0]}), 32'b001);
    chk("msb_res_u", 32'({done[1], aeb[1], agb[1], alb[1]}), 32'b1010);

    // Lower nibble compared unsigned.
    do_start(16'h12F4, 16'h1204);
    @(posedge sysclk);
    @(posedge sysclk);
    #1;
    chk("nib3_cmp_a", 32'(ca[0]), 32'h7);
    chk("nib3_cmp_b", 32'(cb[0]), 32'h8);
    wait_done(lat);
    chk("nib3_lat", 32'(lat), 32'd3);
    chk("nib3_res", 32'({aeb[0], agb[0], alb[0]}), 32'b010);

    // start during RUN ignored; start in done cycle accepted back-to-back.
    do_start(16'h1111, 16'h1112);
    @(posedge sysclk);
    #2;
    op_a  = 16'hFFFF;
    op_b  = 16'h0000;
    start = 1'b1;
    @(posedge sysclk);
    #2 start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_res", 32'({aeb[0], agb[0], alb[0]}), 32'b001);
    do_start(16'h0005, 16'h0003);
    chk("b2b_acc", 32'(busy[0]), 32'd1);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_res", 32'({aeb[0], agb[0], alb[0]}), 32'b010);

    // Abort in the second RUN cycle.
    do_start(16'h1234, 16'h1234);
    @(posedge sysclk);
    #2 abort = 1'b1;
    @(posedge sysclk);
    #1;
    chk("abort_st", 32'({busy[0], done[0], aeb[0], agb[0], alb[0]}), 32'h0);
    #1 abort = 1'b0;
    repeat (5) @(posedge sysclk);
    #2;
    do_start(16'h0001, 16'h0002);
    wait_done(lat);
    chk("post_abort_lat", 32'(lat), 32'd4);
    chk("post_abort_res", 32'({aeb[0], agb[0], alb[0]}), 32'b001);

    // Abort coinciding with the decision edge wins.
    do_start(16'h8000, 16'h0001);
    abort = 1'b1;
    @(posedge sysclk);
    #1;
    chk("abort_win", 32'({busy[0], done[0], aeb[0], agb[0], alb[0]}), 32'h0);
    #1 abort = 1'b0;
    @(posedge sysclk);
    #2;

    // Non-one-hot comparator result counts as unequal; agb/alb copied as presented.
    inj = 1'b1;
    do_start(16'h1234, 16'h1234);
    wait_done(lat);
    chk("inj_lat", 32'(lat), 32'd1);
    chk("inj_res", 32'({aeb[0], agb[0], alb[0]}), 32'b011);
    inj = 1'b0;
    @(posedge sysclk);
    #2;

    // Asynchronous reset mid-RUN.
    do_start(16'h1234, 16'h1234);
    @(posedge sysclk);
    #2 sys_rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge sysclk);
    #2 sys_rst_n = 1'b1;
    @(posedge sysclk);
    #2;
    do_start(16'h1234, 16'h1235);
    wait_done(lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_res", 32'({aeb[0], agb[0], alb[0]}), 32'b001);

    repeat (3) @(posedge sysclk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_seq_ctl.md
# cmp_seq_ctl

Sequencing controller that performs a multi-nibble magnitude compare of two wide operands using a single shared external 4-bit comparator (CMP4-style: AEB/AGB/ALB outputs, two's-complement compare). It walks the operands from the most significant nibble downward, one nibble per clock, and terminates early on the first unequal nibble. It sits between the microcode/control logic that issues compare requests and the one comparator instance in the datapath, so no wide comparator tree is needed.

## Interface
- NIBBLES, 4, operand width in nibbles (operand width = 4*NIBBLES bits); legal range 1..8.
- SIGNED, 1, 1 = operands are two's complement; 0 = operands are unsigned.

- sysclk  in  1  system clock; all state changes on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  compare request; accepted only in IDLE.
- abort  in  1  synchronous cancel of a running compare.
- op_a  in  4*NIBBLES  operand A; sampled on the accepting edge.
- op_b  in  4*NIBBLES  operand B; sampled on the accepting edge.
- cmp_a  out  4  nibble of A driven to the external comparator.
- cmp_b  out  4  nibble of B driven to the external comparator.
- cmp_aeb, cmp_agb, cmp_alb  in  1 each  external comparator results for cmp_a/cmp_b.
- busy  out  1  high while a compare is in progress (state RUN).
- done  out  1  one-cycle pulse: result valid.
- aeb, agb, alb  out  1 each  registered result for A vs B; one-hot once done.

## Operation
- States: IDLE, RUN. done is a registered pulse output, not a separate state.
- IDLE, start=1: latch op_a/op_b, set idx=NIBBLES-1, clear aeb/agb/alb to 000, and go to RUN.
- RUN, each edge: sample the cmp_* inputs for the current idx.
  - cmp_aeb=0: load agb/alb from cmp_agb/cmp_alb, pulse done, and go to IDLE.
  - cmp_aeb=1 and idx=0: set aeb=1, pulse done, and go to IDLE.
  - Otherwise: decrement idx.
- Nibble conditioning (the external comparator always compares signed):
  - Nibble idx=NIBBLES-1 with SIGNED=1: drive the raw nibbles.
  - All other nibbles, and every nibble when SIGNED=0: drive each nibble with bit 3 inverted on both cmp_a and cmp_b. This converts the signed compare into an unsigned compare.
- cmp_a/cmp_b are combinational from the latched operands and idx in RUN, and are 0 in IDLE.
- abort=1 in RUN: go to IDLE, no done pulse, aeb/agb/alb stay 000. abort in IDLE has no effect. If abort and a decision edge coincide, abort wins.
- start while in RUN is ignored; the latched operands are not disturbed.
- Results hold until the next accepted start.
- Illegal cmp_* combinations (not one-hot) are treated as "not equal". agb/alb are copied as presented; the controller does not check them.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, idx=0, and latched operands=0. Outputs busy, done, aeb, agb, alb, cmp_a, cmp_b are all 0. A compare running at reset is lost with no done pulse.
- Latency: start is accepted at edge E0. If the compare decides on the m-th nibble examined (1 ≤ m ≤ NIBBLES), done and the result are high after edge E0+m.
  - Best case: 1 cycle after acceptance.
  - Worst case (equal operands): NIBBLES cycles.
- busy is high from the cycle after E0 until the decision edge, inclusive of the cycles between.
- done is high for exactly one cycle, and the controller is already in IDLE in that cycle. A start asserted during the done cycle is accepted, which gives back-to-back compares with no gap.
- cmp_* inputs are sampled on the same edge that the corresponding cmp_a/cmp_b were driven for. The external comparator path must be single-cycle combinational.
- NIBBLES=1: a single RUN cycle; with SIGNED=1 the raw nibble is compared signed.

## Test plan
- NIBBLES=4, SIGNED=1: a=0x1234, b=0x1234 -> done 4 cycles after acceptance, aeb=1, agb=0, alb=0; busy high for 4 cycles.
- SIGNED=1: a=0x8000, b=0x0001 -> done 1 cycle after acceptance, alb=1. Repeat with SIGNED=0 -> agb=1.
- SIGNED=1: a=0x12F4, b=0x1204 -> third nibble compared as unsigned (F > 0), so agb=1 and done 3 cycles after acceptance. Bench checks cmp_a=0x7 and cmp_b=0x8 on that cycle.
- Run a=0x1111, b=0x1112. Pulse start mid-RUN with different operands -> ignored; result alb=1 after 4 cycles. Assert start in the done cycle -> the new compare is accepted with no gap.
- Assert abort in the 2nd RUN cycle -> IDLE next edge, no done pulse, results 000. A fresh start then completes normally.
- Drop sys_rst_n mid-RUN -> all outputs 0 immediately without waiting for a clock edge. After release, IDLE, and a start completes a full compare.
